// File: rtl/adder_err_eval_pkg.sv
// Shared types, constants and helpers for the approximate-adder error evaluator.
package adder_err_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Cycles spent flushing the two-stage scoring pipeline
    localparam int DRAIN_CYCLES = 2;

    // Saturating add on up to 64-bit quantities; lim is the all-ones value of
    // the caller's accumulator width.
    function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                            input logic [63:0] inc,
                                            input logic [63:0] lim);
        logic [64:0] s;
        s = {1'b0, acc} + {1'b0, inc};
        if (s > {1'b0, lim}) begin
            return lim;
        end
        return s[63:0];
    endfunction

endpackage

// File: rtl/adder_err_opgen.sv
// Operand generator: exhaustive 2W-bit up-counter or Galois LFSR, with a
// remaining-vector counter that flags the last vector to be issued.
module adder_err_opgen
    import adder_err_eval_pkg::*;
#(
    parameter int W     = 16,
    parameter int CNT_W = 2*W+1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic             mode_i,
    input  logic [CNT_W-1:0] num_vec_i,
    input  logic [2*W-1:0]   seed_i,
    output logic [2*W-1:0]   vec_o,
    output logic             last_o
);

    logic [2*W-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             mode_q, mode_d;
    logic [2*W-1:0]   lfsr_next;

    assign lfsr_next = {1'b0, vec_q[2*W-1:1]} ^ (vec_q[0] ? (2*W)'(LFSR_TAPS) : '0);

    // Load a fresh sequence on start, otherwise step once per issued vector
    always_comb begin
        vec_d  = vec_q;
        rem_d  = rem_q;
        mode_d = mode_q;
        if (load_i) begin
            mode_d = mode_i;
            rem_d  = (num_vec_i == '0) ? (CNT_W'(1) << (2*W)) : num_vec_i;
            if (mode_i) begin
                vec_d = (seed_i == '0) ? '1 : seed_i;
            end else begin
                vec_d = '0;
            end
        end else if (adv_i) begin
            rem_d = rem_q - CNT_W'(1);
            vec_d = mode_q ? lfsr_next : vec_q + (2*W)'(1);
        end
    end

    // Generator state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q  <= '0;
            rem_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            vec_q  <= vec_d;
            rem_q  <= rem_d;
            mode_q <= mode_d;
        end
    end

    assign vec_o  = vec_q;
    assign last_o = (rem_q == CNT_W'(1));

endmodule

// File: rtl/adder_err_eval_ctrl.sv
// Sequencer and scoreboard for one approximate adder under test.
// Optional build macro ADDER_ERR_HD_EN adds the Hamming-distance accumulator hd_acc.
module adder_err_eval_ctrl
    import adder_err_eval_pkg::*;
#(
    parameter int W     = 16,
    parameter int CNT_W = 2*W+1,
    parameter int ACC_W = 3*W+2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [2*W-1:0]   seed,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic [W:0]       approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] err_acc,
    output logic [W:0]       max_err
`ifdef ADDER_ERR_HD_EN
    ,
    output logic [ACC_W-1:0] hd_acc
`endif
);

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_e           state_q, state_d;
    logic [1:0]       drain_q, drain_d;
    logic             start_ok, adv, last;
    logic [2*W-1:0]   vec;

    logic             s1_valid_q;
    logic [W:0]       s1_approx_q, s1_exact_q;
    logic [W:0]       diff;

    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d, err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0] err_acc_q, err_acc_d;
    logic [W:0]       max_err_q, max_err_d;

    assign start_ok = start && (state_q == IDLE || state_q == DONE);
    assign adv      = (state_q == RUN) && !last;

    adder_err_opgen #(.W(W), .CNT_W(CNT_W)) u_opgen (
        .clk       (clk),
        .rst       (rst),
        .load_i    (start_ok),
        .adv_i     (adv),
        .mode_i    (mode),
        .num_vec_i (num_vec),
        .seed_i    (seed),
        .vec_o     (vec),
        .last_o    (last)
    );

    assign op_a = vec[2*W-1:W];
    assign op_b = vec[W-1:0];

    // Next-state logic: RUN until the last vector issues, then flush the pipeline
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // S1: capture the adder-under-test result alongside the exact reference
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_approx_q <= '0;
            s1_exact_q  <= '0;
        end else begin
            s1_valid_q  <= (state_q == RUN);
            s1_approx_q <= approx_sum;
            s1_exact_q  <= (W+1)'(op_a) + (W+1)'(op_b);
        end
    end

    assign diff = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                              : (s1_approx_q - s1_exact_q);

    // S2: statistics update; a start clears everything in the same cycle
    always_comb begin
        vec_cnt_d = vec_cnt_q;
        err_cnt_d = err_cnt_q;
        err_acc_d = err_acc_q;
        max_err_d = max_err_q;
        if (start_ok) begin
            vec_cnt_d = '0;
            err_cnt_d = '0;
            err_acc_d = '0;
            max_err_d = '0;
        end else if (s1_valid_q) begin
            vec_cnt_d = vec_cnt_q + CNT_W'(1);
            if (diff != '0) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            err_acc_d = ACC_W'(sat_add(64'(err_acc_q), 64'(diff), 64'(ACC_MAX)));
            if (diff > max_err_q) begin
                max_err_d = diff;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
            err_acc_q <= '0;
            max_err_q <= '0;
        end else begin
            vec_cnt_q <= vec_cnt_d;
            err_cnt_q <= err_cnt_d;
            err_acc_q <= err_acc_d;
            max_err_q <= max_err_d;
        end
    end

`ifdef ADDER_ERR_HD_EN
    logic [ACC_W-1:0] hd_acc_q, hd_acc_d;
    logic [W:0]       hd_bits;
    logic [$clog2(W+2)-1:0] hd_pop;

    assign hd_bits = s1_exact_q ^ s1_approx_q;

    // Population count of the bitwise error pattern
    always_comb begin
        hd_pop = '0;
        for (int i = 0; i <= W; i++) begin
            hd_pop = hd_pop + ($clog2(W+2))'(hd_bits[i]);
        end
    end

    // Hamming-distance accumulator, same clear/update timing as err_acc
    always_comb begin
        hd_acc_d = hd_acc_q;
        if (start_ok) begin
            hd_acc_d = '0;
        end else if (s1_valid_q) begin
            hd_acc_d = ACC_W'(sat_add(64'(hd_acc_q), 64'(hd_pop), 64'(ACC_MAX)));
        end
    end

    // Hamming-distance accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            hd_acc_q <= '0;
        end else begin
            hd_acc_q <= hd_acc_d;
        end
    end

    assign hd_acc = hd_acc_q;
`endif

    assign busy    = (state_q == RUN) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
    assign vec_cnt = vec_cnt_q;
    assign err_cnt = err_cnt_q;
    assign err_acc = err_acc_q;
    assign max_err = max_err_q;

endmodule

// File: tb/tb_adder_err_eval_ctrl.sv
// Directed self-checking bench for adder_err_eval_ctrl.
// A second instance with an 18-bit accumulator exercises saturation.
module tb_adder_err_eval_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, start2, mode;
    logic [32:0] num_vec;
    logic [31:0] seed;
    logic [15:0] op_a, op_b, op_a2, op_b2;
    logic [16:0] approx_sum;
    logic        busy, done, busy2, done2;
    logic [32:0] vec_cnt, err_cnt, vec_cnt2, err_cnt2;
    logic [49:0] err_acc;
    logic [17:0] err_acc2;
    logic [16:0] max_err, max_err2;
    int          model_sel;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc;

    always #5 clk = ~clk;

    // Behavioural adders under test: 0 ideal, 1 low 15 sum bits tied to 0
    always_comb begin
        approx_sum = 17'(op_a) + 17'(op_b);
        if (model_sel == 1) begin
            approx_sum[14:0] = '0;
        end
    end

    adder_err_eval_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .num_vec(num_vec),
        .seed(seed), .op_a(op_a), .op_b(op_b), .approx_sum(approx_sum),
        .busy(busy), .done(done), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
        .err_acc(err_acc), .max_err(max_err)
    );

    // Adder that always returns 0, with a narrow accumulator
    adder_err_eval_ctrl #(.ACC_W(18)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode), .num_vec(num_vec),
        .seed(seed), .op_a(op_a2), .op_b(op_b2), .approx_sum(17'd0),
        .busy(busy2), .done(done2), .vec_cnt(vec_cnt2), .err_cnt(err_cnt2),
        .err_acc(err_acc2), .max_err(max_err2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got=%0h exp=%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse start on dut for one cycle; returns at the negedge after acceptance
    task automatic kick(input logic m, input logic [32:0] nv, input logic [31:0] sd);
        @(negedge clk);
        mode = m; num_vec = nv; seed = sd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count busy cycles (sampled at negedges) until done, with a bound
    task automatic wait_done(output int c);
        int g;
        c = 0;
        g = 0;
        while (!done && g < 20000) begin
            if (busy) c++;
            g++;
            @(negedge clk);
        end
        check("done_reached", 64'(done), 64'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 1'b0;
        num_vec = '0; seed = '0; model_sel = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_done",    64'(done),    64'd0);
        check("rst_op",      64'({op_a, op_b}), 64'd0);
        check("rst_stats",   64'(vec_cnt | err_cnt | 33'(err_acc) | 33'(max_err)), 64'd0);

        // Ideal adder, 1000 exhaustive vectors
        model_sel = 0;
        kick(1'b0, 33'd1000, 32'd0);
        check("ideal_done_lo", 64'(done), 64'd0);
        wait_done(cyc);
        check("ideal_cycles", 64'(cyc),     64'd1002);
        check("ideal_vec",    64'(vec_cnt), 64'd1000);
        check("ideal_err",    64'(err_cnt), 64'd0);
        check("ideal_acc",    64'(err_acc), 64'd0);
        check("ideal_max",    64'(max_err), 64'd0);

        // Low 15 bits zero, vectors op_b = 0..3 -> diffs 0,1,2,3
        model_sel = 1;
        kick(1'b0, 33'd4, 32'd0);
        wait_done(cyc);
        check("trunc4_err", 64'(err_cnt), 64'd3);
        check("trunc4_acc", 64'(err_acc), 64'd6);
        check("trunc4_max", 64'(max_err), 64'd3);
        check("trunc4_vec", 64'(vec_cnt), 64'd4);

        // Single vector
        kick(1'b0, 33'd1, 32'd0);
        wait_done(cyc);
        check("one_cycles", 64'(cyc),     64'd3);
        check("one_vec",    64'(vec_cnt), 64'd1);
        check("one_err",    64'(err_cnt), 64'd0);

        // LFSR with seed 0 on the ideal adder
        model_sel = 0;
        kick(1'b1, 33'd5, 32'd0);
        check("lfsr_first", 64'({op_a, op_b}), 64'hFFFF_FFFF);
        wait_done(cyc);
        check("lfsr_vec",   64'(vec_cnt), 64'd5);
        check("lfsr_err",   64'(err_cnt), 64'd0);

        // Saturation: zero adder, LFSR vectors FFFF/FFFF, FFDF/FFFC, 7FEF/FFFE
        // diffs 1FFFE + 1FFDB = 3FFD9, + 17FED overflows 18 bits -> 3FFFF
        @(negedge clk);
        mode = 1'b1; num_vec = 33'd3; seed = 32'd0; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("sat_op0", 64'({op_a2, op_b2}), 64'hFFFF_FFFF);
        @(negedge clk);
        check("sat_op1", 64'({op_a2, op_b2}), 64'hFFDF_FFFC);
        @(negedge clk);
        check("sat_op2", 64'({op_a2, op_b2}), 64'h7FEF_FFFE);
        repeat (3) @(negedge clk);
        check("sat_done", 64'(done2),    64'd1);
        check("sat_acc",  64'(err_acc2), 64'h3FFFF);
        check("sat_max",  64'(max_err2), 64'h1FFFE);
        check("sat_err",  64'(err_cnt2), 64'd3);
        check("sat_vec",  64'(vec_cnt2), 64'd3);

        // Reset five cycles into a run
        model_sel = 1;
        kick(1'b0, 33'd100, 32'd0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",  64'(busy), 64'd0);
        check("abort_done",  64'(done), 64'd0);
        check("abort_op",    64'({op_a, op_b}), 64'd0);
        check("abort_stats", 64'(vec_cnt | err_cnt | 33'(err_acc) | 33'(max_err)), 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_idle",  64'({busy, done}), 64'd0);
        kick(1'b0, 33'd10, 32'd0);
        wait_done(cyc);
        check("fresh_vec", 64'(vec_cnt), 64'd10);
        check("fresh_err", 64'(err_cnt), 64'd9);
        check("fresh_acc", 64'(err_acc), 64'd45);
        check("fresh_max", 64'(max_err), 64'd9);

        // start during RUN is ignored
        kick(1'b0, 33'd20, 32'd0);
        repeat (6) @(negedge clk);
        mode = 1'b1; num_vec = 33'd5; seed = 32'h1234_5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("ign_cycles", 64'(cyc + 7),  64'd22);
        check("ign_vec",    64'(vec_cnt),  64'd20);
        check("ign_acc",    64'(err_acc),  64'd190);
        check("ign_max",    64'(max_err),  64'd19);
        check("ign_hold_op", 64'({op_a, op_b}), 64'd19);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
